// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: memory-controller req/ack port, decode valid/ready port and redirect inputs.
// master is the fetch queue; slave is whoever sits on the other side.
interface fetch_queue_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
);
   logic                       if_mc_req;
   logic [XLEN-1:0]            if_mc_addr;
   logic                       mc_if_ack;
   logic [XLEN-1:0]            mc_if_data;
   logic                       if_id_valid;
   logic [XLEN-1:0]            if_id_instruc;
   logic [XLEN-1:0]            if_id_nextpc;
   logic                       id_if_ready;
   logic                       id_if_selpcsource;
   logic [1:0]                 id_if_selpctype;
   logic [XLEN-1:0]            id_if_rega;
   logic [XLEN-1:0]            id_if_pcimd2ext;
   logic [XLEN-1:0]            id_if_pcindex;
   logic [$clog2(DEPTH):0]     if_fq_count;

   modport master (
      output if_mc_req, if_mc_addr, if_id_valid, if_id_instruc, if_id_nextpc, if_fq_count,
      input  mc_if_ack, mc_if_data, id_if_ready, id_if_selpcsource, id_if_selpctype,
             id_if_rega, id_if_pcimd2ext, id_if_pcindex
   );

   modport slave (
      input  if_mc_req, if_mc_addr, if_id_valid, if_id_instruc, if_id_nextpc, if_fq_count,
      output mc_if_ack, mc_if_data, id_if_ready, id_if_selpcsource, id_if_selpctype,
             id_if_rega, id_if_pcimd2ext, id_if_pcindex
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one-outstanding req/ack fetcher feeding a DEPTH-entry prefetch queue
// of {instruction, pc+4}; decode redirects flush the queue and squash any in-flight fetch.
module fetch_queue #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     DEPTH      = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(64)
) (
   input logic           clock,
   input logic           reset,
   fetch_queue_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

   state_e          state_q;
   logic            req_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] npc_mem   [DEPTH];
   logic [XLEN-1:0] target;
   logic            redirect, push, pop, has_room, valid;

   always_comb begin
      redirect = bus.id_if_selpcsource;
      valid    = (count_q != '0);
      // A push is only possible from REQ, so an ack with no request outstanding is ignored.
      push     = (state_q == StReq) && bus.mc_if_ack && !redirect;
      pop      = valid && bus.id_if_ready && !redirect;

      count_d = count_q + CW'(push) - CW'(pop);
      if (redirect) count_d = '0;
      has_room = (count_d < CW'(DEPTH));

      target = bus.id_if_pcimd2ext;
      unique case (bus.id_if_selpctype)
         2'b00: target = bus.id_if_pcimd2ext;
         2'b01: target = bus.id_if_rega;
         2'b10: target = bus.id_if_pcindex;
         2'b11: target = EXC_VECTOR;
         default: target = bus.id_if_pcimd2ext;
      endcase
      target[1:0] = 2'b00;

      fpc_d = fpc_q;
      if (redirect)  fpc_d = target;
      else if (push) fpc_d = fpc_q + XLEN'(4);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         fpc_q    <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         count_q <= count_d;
         if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
         end

         unique case (state_q)
            StIdle: begin
               addr_q <= fpc_d;
               if (has_room) begin
                  state_q <= StReq;
                  req_q   <= 1'b1;
               end
            end
            StReq: begin
               if (redirect && !bus.mc_if_ack) begin
                  // Squashed request still owes us an ack; keep presenting its address.
                  state_q <= StDrop;
               end else if (bus.mc_if_ack) begin
                  addr_q <= fpc_d;
                  if (has_room) begin
                     state_q <= StReq;
                  end else begin
                     state_q <= StIdle;
                     req_q   <= 1'b0;
                  end
               end
            end
            StDrop: begin
               if (bus.mc_if_ack) begin
                  state_q <= StReq;
                  addr_q  <= fpc_d;
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // Queue storage needs no reset: entries are only visible while counted as valid.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= bus.mc_if_data;
         npc_mem[wr_ptr_q]   <= fpc_q + XLEN'(4);
      end
   end

   assign bus.if_mc_req     = req_q;
   assign bus.if_mc_addr    = addr_q;
   assign bus.if_id_valid   = valid;
   assign bus.if_id_instruc = valid ? instr_mem[rd_ptr_q] : '0;
   assign bus.if_id_nextpc  = valid ? npc_mem[rd_ptr_q] : '0;
   assign bus.if_fq_count   = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table of per-cycle vectors plus a reset-in-DROP sequence.
module tb_fetch_queue;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .RESET_PC  (32'h0),
      .EXC_VECTOR(32'd64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory returns a word tagged with the address it was read from.
   assign bus.mc_if_data = mem_word(bus.if_mc_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ack;
      logic        ready;
      logic        redir;
      logic [1:0]  ptype;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_npc;
      logic [2:0]  e_count;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic ready, input logic redir,
                        input logic [1:0] ptype, input logic [31:0] tgt);
      bus.mc_if_ack         = ack;
      bus.id_if_ready       = ready;
      bus.id_if_selpcsource = redir;
      bus.id_if_selpctype   = ptype;
      bus.id_if_pcimd2ext   = (ptype == 2'b00) ? tgt : 32'h1111_1110;
      bus.id_if_rega        = (ptype == 2'b01) ? tgt : 32'h2222_2220;
      bus.id_if_pcindex     = (ptype == 2'b10) ? tgt : 32'h3333_3330;
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] npc, input logic [2:0] cnt);
      check({tag, ".req"}, {31'd0, bus.if_mc_req}, {31'd0, req});
      if (req) check({tag, ".addr"}, bus.if_mc_addr, addr);
      check({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
      check({tag, ".instr"}, bus.if_id_instruc, valid ? mem_word(npc - 32'd4) : 32'd0);
      check({tag, ".nextpc"}, bus.if_id_nextpc, valid ? npc : 32'd0);
      check({tag, ".count"}, {29'd0, bus.if_fq_count}, {29'd0, cnt});
   endtask

   initial begin
      tests = 0;
      fails = 0;
      //            ack   rdy   rdr   type   tgt       req   addr      vld   npc      cnt
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   3'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4,   3'd1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8,   3'd1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'hC,   1'b1, 32'hC,   3'd1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   3'd2};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h14,  1'b1, 32'hC,   3'd3};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'hC,   3'd4};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'hC,   3'd4};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  3'd3};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  3'd3};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  3'd3};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h18,  1'b1, 32'h10,  3'd3};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10,  3'd4};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h14,  3'd3};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h18,  3'd2};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 2'b11, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0,   3'd0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h44,  1'b1, 32'h44,  3'd1};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h44,  1'b1, 32'h44,  3'd1};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h103, 1'b1, 32'h44,  1'b0, 32'h0,   3'd0};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h44,  1'b0, 32'h0,   3'd0};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   3'd0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104, 3'd1};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h207, 1'b1, 32'h104, 1'b0, 32'h0,   3'd0};
      vecs[23] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h302, 1'b1, 32'h104, 1'b0, 32'h0,   3'd0};
      vecs[24] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0,   3'd0};

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
      check("reset.addr", bus.if_mc_addr, 32'h0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].ptype, vecs[i].tgt);
         @(posedge clock);
         #1;
         expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_npc, vecs[i].e_count);
      end

      // Enter DROP, then pull reset mid-cycle with an ack pending.
      drive(1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
      @(posedge clock);
      #1;
      expect_out("drop", 1'b1, 32'h300, 1'b0, 32'h0, 3'd0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      expect_out("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
      check("rst_async.addr", bus.if_mc_addr, 32'h0);
      @(posedge clock);
      #1;
      expect_out("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      expect_out("rst_first", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
      @(posedge clock);
      #1;
      expect_out("rst_push", 1'b1, 32'h4, 1'b1, 32'h4, 3'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
